i2s_tx: RTL
===========

# i2s_tx

Serializer that converts stereo PCM sample pairs into the I2S stream (`i2s_bck`, `i2s_ws`, `i2s_d0`) driven out of `amp_frontend` to the amplifier. It is the stage directly downstream of the sample decoder inside the frontend. It accepts one left/right pair per frame through a valid/ready handshake and buffers one pair ahead. On underrun it emits a silent frame and flags it.

## Interface
- `SAMPLE_W`, 24: sample width in bits; must be ≤ `SLOT_W`.
- `SLOT_W`, 32: bits per channel slot; frame length is 2·`SLOT_W` bck periods.
- `BCK_HALF`, 16: clk cycles per bck half-period; the default gives 3.125 MHz bck at 100 MHz clk.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = run the stream; 0 = stop after the current frame completes.
- `s_valid`  in  1  sample pair valid.
- `s_ready`  out  1  holding register empty; a transfer occurs when `s_valid && s_ready` at a clk edge.
- `s_left`  in  `SAMPLE_W`  left sample, two's complement.
- `s_right`  in  `SAMPLE_W`  right sample, two's complement.
- `i2s_bck`  out  1  bit clock.
- `i2s_ws`  out  1  word select: 0 = left, 1 = right.
- `i2s_d0`  out  1  serial data, MSB first.
- `underrun`  out  1  one-clk pulse when a frame starts with no buffered pair.
- `running`  out  1  1 in RUN or DRAIN.

## Operation
- Reset values (asserted asynchronously): `i2s_bck`=0, `i2s_ws`=0, `i2s_d0`=0, `underrun`=0, `running`=0, `s_ready`=1. The holding register is flushed and the state is IDLE.
- Storage is a holding register (one pair plus a valid bit) and a frame shift register (2·`SLOT_W` bits).
- Each slot is the sample MSB-aligned with zero LSB padding. Samples pass through unchanged; no rounding or saturation is applied.
- States:
  - IDLE: bck/ws/d0 held at 0. When `enable`=1 and the holding register is valid, load the frame register from it, clear its valid bit, set bit_cnt=0 and go to RUN.
  - RUN: serialize. If `enable`=0 is sampled at any point, go to DRAIN.
  - DRAIN: identical to RUN. At the end of the frame, return to IDLE if `enable`=0, otherwise continue as RUN with no gap.
- Bit counter b runs 0..2·`SLOT_W`−1 and advances on each bck falling edge.
  - `i2s_d0` = frame bit b, MSB of left at b=0, MSB of right at b=`SLOT_W`.
  - `i2s_ws` = 1 for b in [`SLOT_W`−1, 2·`SLOT_W`−2], else 0. This makes ws lead data by one bck, per I2S.
- Frame boundary is the falling edge that wraps b from 2·`SLOT_W`−1 to 0. On that edge the frame register is loaded:
  - from the holding register if it is valid, clearing its valid bit;
  - otherwise with all zeros, and `underrun` pulses for one clk.
- The frame load uses the registered holding-valid bit. A handshake in the same clk as the boundary does not feed that frame: the boundary counts as an underrun and the new pair waits for the next frame.
- Leaving DRAIN to IDLE keeps holding-register contents; nothing is flushed.

## Timing
- bck divider counts 0..`BCK_HALF`−1 and toggles `i2s_bck` at terminal count. bck period = 2·`BCK_HALF` clk; frame = 4·`SLOT_W`·`BCK_HALF` clk (2048 at defaults).
- `i2s_d0` and `i2s_ws` change only on the clk edge where bck falls, so they are stable at every bck rising edge.
- Start latency:
  - handshake at edge N fills the holding register;
  - at edge N+1, IDLE→RUN, d0 = left MSB, ws=0, bck=0;
  - first bck rise at edge N+1+`BCK_HALF`;
  - `s_ready` returns to 1 at edge N+1.
- `s_ready` drops the edge after a handshake and rises on the edge the holding register is consumed.
- DRAIN→IDLE happens on the frame-boundary edge; outputs are 0 from that edge on.
- All outputs are registered. `running` and `underrun` reflect state after the edge.

## Structure
- Package `amp_frontend_pkg` holds:
  - the state enum (IDLE, RUN, DRAIN);
  - I2S defaults `I2S_SLOT_W`=32 and `I2S_BCK_HALF`=16.
- Sub-module `i2s_bck_gen`: divider producing `i2s_bck` plus one-clk `bck_fall`/`bck_rise` strobes, with synchronous clear when in IDLE. The rest is a single FSM plus datapath.

## Test plan
- Reset mid-frame (drop `reset` at b=20) → all outputs 0 immediately, `s_ready`=1, and no output after release until a new pair arrives.
- Single pair L=0x800001, R=0x7FFFFF with `enable`=1 → bench samples d0 on bck rise and recovers exactly L and R, each followed by 8 zeros. ws toggles one bck before each MSB; frame = 2048 clk.
- Continuous stream of 8 pairs (counting pattern) with `s_valid` always high → no `underrun`, pairs appear in order, and `s_ready` duty is one acceptance per frame.
- Stall the source after pair 2 → frame 3 is all zeros with one `underrun` pulse at its boundary. A pair supplied in the boundary cycle appears in frame 4.
- Drop `enable` at b=40 → current frame completes, then bck/ws/d0=0 and `running`=0 at the boundary. A held pair is retained and plays first after re-enable.
- Toggle `enable` 1→0→1 within one frame → no gap, no IDLE visit, and `running` stays 1.

Source files
------------

// File: rtl/amp_frontend_pkg.sv
// Shared types and I2S defaults for the amplifier frontend.
package amp_frontend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } i2s_state_e;

    localparam int I2S_SLOT_W   = 32;
    localparam int I2S_BCK_HALF = 16;

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock divider: toggles bck every BCK_HALF clk and flags the edge at which
// bck is about to rise or fall, so the caller can update data on that same edge.
module i2s_bck_gen #(
    parameter int BCK_HALF = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic bck,
    output logic bck_fall,
    output logic bck_rise
);

    localparam int DIV_W = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             bck_q, bck_d;
    logic             tc;

    assign tc = (div_q == DIV_W'(BCK_HALF - 1));

    always_comb begin
        div_d = tc ? '0 : div_q + 1'b1;
        bck_d = bck_q ^ tc;
        if (clr) begin
            div_d = '0;
            bck_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            bck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            bck_q <= bck_d;
        end
    end

    assign bck      = bck_q;
    assign bck_fall = tc && bck_q && !clr;
    assign bck_rise = tc && !bck_q && !clr;

endmodule

// File: rtl/i2s_tx.sv
// Stereo PCM to I2S serializer with a one-pair holding register; frames with
// no buffered pair are sent as silence and flagged on underrun.
module i2s_tx
    import amp_frontend_pkg::*;
#(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = I2S_SLOT_W,
    parameter int BCK_HALF = I2S_BCK_HALF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                i2s_bck,
    output logic                i2s_ws,
    output logic                i2s_d0,
    output logic                underrun,
    output logic                running
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] WS_LO  = CNT_W'(SLOT_W - 1);
    localparam logic [CNT_W-1:0] WS_HI  = CNT_W'(FRAME_W - 2);

    i2s_state_e          state_q, state_d;
    logic                hold_vld_q, hold_vld_d;
    logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [CNT_W-1:0]    b_q, b_d, b_next;
    logic                ws_q, ws_d;
    logic                underrun_q, underrun_d;
    logic                running_q, running_d;
    logic                s_ready_q, s_ready_d;
    logic                bck_fall, bck_rise_unused;
    logic [SLOT_W-1:0]   slot_l, slot_r;

    i2s_bck_gen #(.BCK_HALF(BCK_HALF)) u_bck_gen (
        .clk      (clk),
        .rst_n    (reset),
        .clr      (state_q == IDLE),
        .bck      (i2s_bck),
        .bck_fall (bck_fall),
        .bck_rise (bck_rise_unused)
    );

    // MSB-aligned slots, LSBs zero-padded
    assign slot_l = SLOT_W'(hold_l_q) << (SLOT_W - SAMPLE_W);
    assign slot_r = SLOT_W'(hold_r_q) << (SLOT_W - SAMPLE_W);
    assign b_next = (b_q == B_LAST) ? '0 : b_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        hold_vld_d = hold_vld_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        frame_d    = frame_q;
        b_d        = b_q;
        ws_d       = ws_q;
        underrun_d = 1'b0;

        if (s_valid && !hold_vld_q) begin
            hold_vld_d = 1'b1;
            hold_l_d   = s_left;
            hold_r_d   = s_right;
        end

        case (state_q)
            IDLE: begin
                if (enable && hold_vld_q) begin
                    state_d    = RUN;
                    frame_d    = {slot_l, slot_r};
                    hold_vld_d = 1'b0;
                    b_d        = '0;
                    ws_d       = 1'b0;
                end
            end
            default: begin
                if (state_q == RUN && !enable) state_d = DRAIN;
                if (bck_fall) begin
                    b_d  = b_next;
                    ws_d = (b_next >= WS_LO) && (b_next <= WS_HI);
                    if (b_q != B_LAST) begin
                        frame_d = frame_q << 1;
                    end else if (!enable) begin
                        // Frame done with the stream stopped: go quiet, keep any held pair.
                        state_d = IDLE;
                        frame_d = '0;
                    end else begin
                        state_d = RUN;
                        if (hold_vld_q) begin
                            frame_d    = {slot_l, slot_r};
                            hold_vld_d = 1'b0;
                        end else begin
                            frame_d    = '0;
                            underrun_d = 1'b1;
                        end
                    end
                end
            end
        endcase

        running_d = (state_d != IDLE);
        s_ready_d = !hold_vld_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_vld_q <= 1'b0;
            hold_l_q   <= '0;
            hold_r_q   <= '0;
            frame_q    <= '0;
            b_q        <= '0;
            ws_q       <= 1'b0;
            underrun_q <= 1'b0;
            running_q  <= 1'b0;
            s_ready_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_vld_q <= hold_vld_d;
            hold_l_q   <= hold_l_d;
            hold_r_q   <= hold_r_d;
            frame_q    <= frame_d;
            b_q        <= b_d;
            ws_q       <= ws_d;
            underrun_q <= underrun_d;
            running_q  <= running_d;
            s_ready_q  <= s_ready_d;
        end
    end

    assign i2s_d0   = frame_q[FRAME_W-1];
    assign i2s_ws   = ws_q;
    assign underrun = underrun_q;
    assign running  = running_q;
    assign s_ready  = s_ready_q;

endmodule
